// File: rtl/energy_pkg.sv
// energy_pkg: FSM state encoding and width helpers for the energy accumulator
package energy_pkg;
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
   function automatic int dot_width(input int vs, input int jw);
      return $clog2(vs) + jw;
   endfunction
   function automatic int energy_width(input int vs, input int dw);
      return dw + $clog2(vs) + 1;
   endfunction
endpackage

// File: rtl/adder_subtractor_unit.sv
// adder_subtractor_unit: y = a - b when sub is set, otherwise a + b
module adder_subtractor_unit #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] y
);
   assign y = sub ? a - b : a + b;
endmodule

// File: rtl/energy_accumulator.sv
// energy_accumulator: signed sum of sigma-weighted dot products, with best-energy tracking
module energy_accumulator
   import energy_pkg::*;
#(
   parameter int VECTOR_SIZE     = 256,
   parameter int J_ELEMENT_WIDTH = 4,
   parameter int DOT_WIDTH       = dot_width(VECTOR_SIZE, J_ELEMENT_WIDTH),
   parameter int ENERGY_WIDTH    = energy_width(VECTOR_SIZE, DOT_WIDTH)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [VECTOR_SIZE-1:0]         sigma,
   input  logic                           dot_valid,
   output logic                           dot_ready,
   input  logic signed [DOT_WIDTH-1:0]    dot_in,
   output logic [$clog2(VECTOR_SIZE)-1:0] col_idx,
   output logic                           energy_valid,
   input  logic                           energy_ready,
   output logic signed [ENERGY_WIDTH-1:0] energy_out,
   output logic                           busy,
   output logic signed [ENERGY_WIDTH-1:0] best_energy,
   output logic                           best_valid,
   output logic                           new_best
);
   localparam int CW = $clog2(VECTOR_SIZE);
   state_t state, state_nx;
   logic [VECTOR_SIZE-1:0] sigma_q;
   logic signed [ENERGY_WIDTH-1:0] acc, dot_ext, sum;
   logic xfer, last, hs, better;
   assign dot_ready    = state == ACCUM;
   assign energy_valid = state == DONE;
   assign busy         = state != IDLE;
   assign energy_out   = acc;
   assign xfer         = dot_valid & dot_ready;
   assign last         = col_idx == CW'(VECTOR_SIZE - 1);
   assign hs           = energy_valid & energy_ready;
   assign better       = !best_valid || acc < best_energy;
   // sign extension first, so negating the most negative dot product cannot overflow
   assign dot_ext      = ENERGY_WIDTH'(dot_in);
   adder_subtractor_unit #(.WIDTH(ENERGY_WIDTH)) u_addsub (
      .a  (acc),
      .b  (dot_ext),
      .sub(~sigma_q[col_idx]),
      .y  (sum)
   );
   always_comb begin
      state_nx = state;
      state_nx = (state == IDLE && start) ? ACCUM :
                 (xfer && last)           ? DONE  :
                 hs                       ? IDLE  : state;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         acc         <= '0;
         col_idx     <= '0;
         sigma_q     <= '0;
         best_energy <= '0;
         best_valid  <= 1'b0;
         new_best    <= 1'b0;
      end else begin
         state    <= state_nx;
         new_best <= hs && better;
         if (state == IDLE && start) begin
            sigma_q <= sigma;
            acc     <= '0;
            col_idx <= '0;
         end
         if (xfer) begin
            acc     <= sum;
            col_idx <= last ? '0 : col_idx + 1'b1;
         end
         if (hs && better) begin
            best_energy <= acc;
            best_valid  <= 1'b1;
         end
      end
   end
endmodule
